// File: rtl/dffbank_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dffbank_pkg
// Shared definitions for the round-robin register-bank arbiter:
//   - default parameter values
//   - FSM state encoding (ST_IDLE / ST_SERVE)
//   - rr_pick(): round-robin winner search starting at the pointer
// Ports: none (package).
// Optional feature macro used by the arbiter: DFFBANK_ARB_LOCK_EN.
// ---------------------------------------------------------------------------
package dffbank_pkg;

  localparam int NREQ_DEF   = 4;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;

  // NREQ is limited to 8, so a 3-bit index covers every requester.
  localparam int MAX_NREQ = 8;
  localparam int PTR_W    = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  // Returns the first requester with its bit set, searching upward from
  // ptr and wrapping modulo nreq. Returns 0 when nothing is requesting;
  // the caller only uses the result when some request is present.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                               input logic [PTR_W-1:0]    ptr,
                                               input int                  nreq);
    logic [PTR_W-1:0] win;
    logic             found;
    int               idx;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (i < nreq) begin
        idx = (int'(ptr) + i) % nreq;
        if (!found && req[idx[PTR_W-1:0]]) begin
          win   = idx[PTR_W-1:0];
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/dffbank_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// dffbank_rr_arbiter_if
// Bundles the requester-side bus of the arbiter.
//   req   [NREQ]          per-requester request, held until ack
//   we    [NREQ]          per-requester write enable (0 = read)
//   addr  [NREQ*ADDR_W]   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   wdata [NREQ*DATA_W]   packed write data, requester i at [i*DATA_W +: DATA_W]
//   lock  [NREQ]          burst lock (only with DFFBANK_ARB_LOCK_EN)
//   gnt   [NREQ]          one-hot registered grant
//   ack   [NREQ]          one-hot registered completion pulse
//   rdata [DATA_W]        word read by the last acked transaction
//   busy                  high while the arbiter is serving
// Modports: master (requester side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface dffbank_rr_arbiter_if
  import dffbank_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
`ifdef DFFBANK_ARB_LOCK_EN
  logic [NREQ-1:0]        lock;
`endif
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      rdata;
  logic                   busy;

  modport master (
    output req, we, addr, wdata,
`ifdef DFFBANK_ARB_LOCK_EN
    output lock,
`endif
    input  gnt, ack, rdata, busy
  );

  modport slave (
    input  req, we, addr, wdata,
`ifdef DFFBANK_ARB_LOCK_EN
    input  lock,
`endif
    output gnt, ack, rdata, busy
  );

endinterface

// File: rtl/dffbank_store.sv
// ---------------------------------------------------------------------------
// dffbank_store
// DEPTH x DATA_W flip-flop register bank, DEPTH = 2**ADDR_W.
//   clk      rising-edge clock
//   rst_n    asynchronous active-low clear of every word
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  combinational read data (value before any write this cycle)
// ---------------------------------------------------------------------------
module dffbank_store #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read gives the caller the old word in the same cycle
  // the write is issued, which is what read-before-write relies on.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dffbank_rr_arbiter.sv
// ---------------------------------------------------------------------------
// dffbank_rr_arbiter
// Round-robin arbiter that shares one dffbank_store among NREQ requesters.
// Each grant performs one transaction: a write, or a read that returns the
// word held before the write, with registered ack and rdata.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    dffbank_rr_arbiter_if.slave (req/we/addr/wdata in,
//          gnt/ack/rdata/busy out, plus lock when enabled)
// Optional feature macro: DFFBANK_ARB_LOCK_EN -- a requester holding lock
// keeps the grant and gets one transaction per cycle.
// ---------------------------------------------------------------------------
module dffbank_rr_arbiter
  import dffbank_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dffbank_rr_arbiter_if.slave  bus
);

  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       win_q, win_d;
  logic [NREQ-1:0]        gnt_q, gnt_d;
  logic [NREQ-1:0]        ack_q, ack_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   busy_q, busy_d;

  logic [MAX_NREQ-1:0]    reqWide;
  logic [PTR_W-1:0]       pick;
  logic [PTR_W-1:0]       ptrNext;
  logic                   selReq;
  logic                   selWe;
  logic [ADDR_W-1:0]      selAddr;
  logic [DATA_W-1:0]      selWdata;
`ifdef DFFBANK_ARB_LOCK_EN
  logic                   selLock;
`endif
  logic                   bankWe;
  logic [DATA_W-1:0]      bankRdata;

  assign reqWide = MAX_NREQ'(bus.req);
  assign pick    = rr_pick(reqWide, ptr_q, NREQ);
  assign ptrNext = (win_q == PTR_W'(NREQ - 1)) ? '0 : PTR_W'(win_q + 1'b1);

  // Select the live inputs of the registered winner; a constant-index loop
  // keeps the packed slicing static.
  always_comb begin
    selReq   = 1'b0;
    selWe    = 1'b0;
    selAddr  = '0;
    selWdata = '0;
`ifdef DFFBANK_ARB_LOCK_EN
    selLock  = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (win_q == PTR_W'(i)) begin
        selReq   = bus.req[i];
        selWe    = bus.we[i];
        selAddr  = bus.addr[i*ADDR_W +: ADDR_W];
        selWdata = bus.wdata[i*DATA_W +: DATA_W];
`ifdef DFFBANK_ARB_LOCK_EN
        selLock  = bus.lock[i];
`endif
      end
    end
  end

  // Next-state logic. IDLE picks a winner and raises gnt; SERVE performs
  // the winner's transaction if it is still requesting, then rotates the
  // pointer past the winner whether or not it completed.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    bankWe  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          win_d   = pick;
          gnt_d   = ONE_HOT0 << pick;
          busy_d  = 1'b1;
          state_d = ST_SERVE;
        end else begin
          gnt_d  = '0;
          busy_d = 1'b0;
        end
      end
      ST_SERVE: begin
        if (selReq) begin
          rdata_d = bankRdata;
          bankWe  = selWe;
          ack_d   = ONE_HOT0 << win_q;
        end
`ifdef DFFBANK_ARB_LOCK_EN
        if (selReq && selLock) begin
          state_d = ST_SERVE;
        end else begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = ptrNext;
          state_d = ST_IDLE;
        end
`else
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = ptrNext;
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointer and output registers. Reset aborts any transaction in
  // flight; the bank itself is cleared by the same reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  dffbank_store #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (bankWe),
    .waddr_i (selAddr),
    .wdata_i (selWdata),
    .raddr_i (selAddr),
    .rdata_o (bankRdata)
  );

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

endmodule

// File: doc/dffbank_rr_arbiter.md
Name: dffbank_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one small register bank among NREQ requesters.
- The bank is DEPTH words of DATA_W bits, built from D flip-flop cells.
- One transaction per grant: a write, or a read returning the pre-write word, with a registered ack and rdata.
- Sits between requester blocks and the shared flip-flop storage; the requesters never touch the bank directly.

Parameters:
- NREQ, 4: number of requesters (2..8).
- DATA_W, 8: bank word width.
- ADDR_W, 2: address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request; held high until ack.
- we  in  NREQ  per-requester write enable (0 = read).
- addr  in  NREQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- wdata  in  NREQ*DATA_W  packed write data; requester i occupies [i*DATA_W +: DATA_W].
- gnt  out  NREQ  one-hot grant, registered.
- ack  out  NREQ  one-hot single-cycle completion pulse, registered.
- rdata  out  DATA_W  word read by the last acked transaction, registered.
- busy  out  1  high while in SERVE.

Behaviour:
- Reset (async, rst_n=0): gnt=0, ack=0, rdata=0, busy=0, every bank word=0, RR pointer=0, state=IDLE. Reset mid-SERVE aborts the transaction with no bank write.
- FSM states: IDLE, SERVE.
- IDLE:
  - ack cleared every cycle.
  - If |req, winner = first set bit searching upward from the pointer, wrapping modulo NREQ.
  - gnt <= onehot(winner), busy <= 1, go to SERVE.
  - If req == 0, stay in IDLE.
- SERVE (exactly one cycle): uses the live inputs of winner w at the clock edge.
  - If req[w]=1:
    - rdata <= bank[addr_w] (old value, read-before-write).
    - If we[w], bank[addr_w] <= wdata_w.
    - ack <= onehot(w).
  - If req[w]=0 (requester withdrew): no write, no ack, rdata unchanged.
  - Always: gnt <= 0, busy <= 0, pointer <= (w+1) mod NREQ, next state IDLE.
- Latency and throughput:
  - req sampled at edge 0 -> gnt at edge 1 -> ack and rdata at edge 2.
  - Maximum throughput is one transaction per 2 cycles.
- Requester contract: drop req in the cycle ack is seen, otherwise it is re-arbitrated as a new request.
- Fairness: with all requesters active, grants rotate 0,1,2,3,0,... A requester waits at most NREQ transactions.
- Simultaneous requests: only the winner is served; the others stay pending, with no loss and no change to their state.
- Address width: addr is exactly ADDR_W bits, so no out-of-range access exists.
- gnt and ack are never both nonzero in the same cycle.
- ack is at most one-hot.

Optional Feature:
- Macro DFFBANK_ARB_LOCK_EN.
- When defined:
  - Extra input port lock, NREQ bits.
  - In SERVE, if req[w] and lock[w] are both 1, the transaction completes and ack pulses.
  - gnt stays onehot(w), state stays SERVE, pointer unchanged.
  - The result is back-to-back bursts of one transaction per cycle.
  - Dropping lock[w] releases the grant after the current transaction and rotates the pointer normally.
- When undefined: no lock port; behaviour is exactly as above.

Decomposition:
- Shared package dffbank_pkg:
  - State encoding constants ST_IDLE=1'b0, ST_SERVE=1'b1.
  - Default parameter values.
  - Helper function rr_pick(req, ptr), returning the winner index.
- One natural sub-module: dffbank_store, the DEPTH x DATA_W flip-flop array with async active-low clear, one write port and one read port.
- The arbiter FSM and pointer logic stay in the top module.

Test Plan:
- Reset then single write: req[2]=1, we[2]=1, addr2=1, wdata2=8'hA5.
  - Expect gnt=4'b0100 at edge 1 and ack=4'b0100 at edge 2.
  - A following read by requester 0 at addr 1 returns rdata=8'hA5.
- All four requesting writes to distinct addresses: grant order 0,1,2,3, acks 2 cycles apart, all four words correct.
- Read-before-write: bank[3]=8'h11, then write 8'h22 to addr 3. Expect rdata=8'h11 on that ack; a subsequent read returns 8'h22.
- Requester 1 drops req during SERVE: no ack, bank unchanged, pointer advances to 2.
- rst_n pulsed low in the middle of SERVE for a write of 8'hFF:
  - Outputs go to 0 immediately, asynchronously.
  - The bank word stays 0.
  - The next arbitration starts from requester 0.
- With DFFBANK_ARB_LOCK_EN: lock[3]=1 for 3 cycles while requesters 0 and 3 both request.
  - Expect 3 consecutive ack[3] pulses with gnt held.
  - Then requester 0 is granted.
